// File: rtl/keypad_pkg.sv
// Shared state type and width helper for the matrix-keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_RELEASE} kp_state_t;

  function automatic int kp_code_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Pin-side and key-output signals of the keypad scanner, grouped with modports.
interface keypad_scan_debounce_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  import keypad_pkg::*;

  localparam int CW = kp_code_w(ROWS, COLS);

  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic [CW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;

  modport master (input col_n, output row_n, key_code, key_valid, key_held);
  modport slave  (output col_n, input row_n, key_code, key_valid, key_held);

endinterface

// File: rtl/keypad_scan_debounce_sync.sv
// Two-flop synchroniser for the active-low column inputs; idles at all-1s.
module kp_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix-keypad scanner with press/release debounce and one strobe per key.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE_CYC  = 20000,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input logic                    clk,
  input logic                    reset,
  keypad_scan_debounce_if.master kp
);
  localparam int CW  = kp_code_w(ROWS, COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int BW  = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  kp_state_t       state;
  logic [COLS-1:0] col_s;
  logic [RW-1:0]   row, row_next;
  logic [CLW-1:0]  col, low_col;
  logic [DW-1:0]   dwell;
  logic [BW-1:0]   db_cnt;
  logic [CW-1:0]   key_code;
  logic            key_valid, key_held, any_low;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPW  = $clog2(RMAX + 1);
  localparam logic [RPW-1:0] RD_LAST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_PERIOD - 1);
  logic [RPW-1:0] rep_cnt;
  logic           rep_armed;
  logic           rep_hit;
  assign rep_hit = (rep_cnt == (rep_armed ? RP_LAST : RD_LAST));
`else
  // Repeat timing parameters are accepted but have no effect in this build.
  logic unused_repeat;
  assign unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  kp_sync #(.W(COLS)) u_sync (.clk(clk), .reset(reset), .d(kp.col_n), .q(col_s));

  // Lowest-index active column wins when several are down on one row.
  always_comb begin
    any_low = ~&col_s;
    low_col = '0;
    for (int i = COLS - 1; i >= 0; i--)
      if (!col_s[i]) low_col = CLW'(i);
  end

  assign row_next = (row == ROW_LAST) ? '0 : row + RW'(1);

  always_comb begin
    kp.row_n      = '1;
    kp.row_n[row] = 1'b0;
  end

  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = key_held;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      row       <= '0;
      col       <= '0;
      dwell     <= '0;
      db_cnt    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN:
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (any_low) begin
              col    <= low_col;
              db_cnt <= '0;
              state  <= DB_PRESS;
            end else begin
              row <= row_next;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        DB_PRESS:
          if (col_s[col]) begin
            row   <= row_next;
            dwell <= '0;
            state <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            key_code  <= CW'(int'(row) * COLS + int'(col));
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
`endif
          end else begin
            db_cnt <= db_cnt + BW'(1);
          end
        // Other keys are ignored here; only the latched column is watched.
        HELD:
          if (col_s[col]) begin
            db_cnt <= '0;
            state  <= DB_RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_hit) begin
            if (!key_valid) begin
              key_valid <= 1'b1;
              rep_cnt   <= '0;
              rep_armed <= 1'b1;
            end
          end else begin
            rep_cnt <= rep_cnt + RPW'(1);
          end
`endif
        DB_RELEASE:
          if (!col_s[col]) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            key_held <= 1'b0;
            row      <= row_next;
            dwell    <= '0;
            state    <= SCAN;
          end else begin
            db_cnt <= db_cnt + BW'(1);
          end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
